// File: rtl/rng_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rng_pkg
// Purpose  : Shared constants and von Neumann state encoding for the ADC
//            entropy extractor.
// Revision : 1.0 - initial release
// ============================================================================
package rng_pkg;

    localparam int c_DEF_DATA_WIDTH = 14;
    localparam int c_DEF_TAP_BITS   = 4;
    localparam int c_DEF_WORD_WIDTH = 8;
    localparam int c_DEF_FIFO_DEPTH = 16;
    localparam int c_DEF_REP_LIMIT  = 32;

    localparam int c_DROP_CNT_W = 16;

    localparam logic [0:0] c_VN_IDLE       = 1'b0;
    localparam logic [0:0] c_VN_HAVE_FIRST = 1'b1;

endpackage
`default_nettype wire

// File: rtl/rng_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rng_sync_fifo
// Purpose  : Single-clock show-ahead FIFO with full/empty/level outputs.
// Revision : 1.0 - initial release
// ============================================================================
module rng_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int               c_AW         = $clog2(DEPTH);
    localparam logic [c_AW:0]    c_PTR_ONE    = (c_AW+1)'(1);
    localparam logic [c_AW:0]    c_PTR_ZERO   = '0;
    localparam logic [c_AW:0]    c_FULL_LEVEL = (c_AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_head;
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;

    logic [c_AW:0]    w_level;
    logic             w_pop;
    logic             w_wr;
    logic [c_AW:0]    w_rd_next;
    logic [c_AW:0]    w_wr_next;

    assign w_level   = r_wr_ptr - r_rd_ptr;
    assign o_full    = (w_level == c_FULL_LEVEL);
    assign o_empty   = (w_level == c_PTR_ZERO);
    assign o_level   = w_level;
    assign o_data    = r_head;

    // A full FIFO still takes a word when the head leaves in the same cycle.
    assign w_pop     = i_pop & ~o_empty;
    assign w_wr      = i_push & (~o_full | w_pop);
    assign w_rd_next = r_rd_ptr + (w_pop ? c_PTR_ONE : c_PTR_ZERO);
    assign w_wr_next = r_wr_ptr + (w_wr  ? c_PTR_ONE : c_PTR_ZERO);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_head   <= '0;
        end else begin
            r_wr_ptr <= w_wr_next;
            r_rd_ptr <= w_rd_next;
            // Head is registered; it holds its last value once the FIFO drains.
            if (w_wr_next != w_rd_next) begin
                if (w_wr && (w_rd_next == r_wr_ptr)) begin
                    r_head <= i_data;
                end else begin
                    r_head <= r_mem[w_rd_next[c_AW-1:0]];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/adc_entropy_extractor.sv
`default_nettype none
// ============================================================================
// Module   : adc_entropy_extractor
// Purpose  : ADC LSB parity -> repetition health test -> von Neumann
//            debiaser -> byte packer -> output FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module adc_entropy_extractor
    import rng_pkg::*;
#(
    parameter int P_DATA_WIDTH = c_DEF_DATA_WIDTH,
    parameter int P_TAP_BITS   = c_DEF_TAP_BITS,
    parameter int P_WORD_WIDTH = c_DEF_WORD_WIDTH,
    parameter int P_FIFO_DEPTH = c_DEF_FIFO_DEPTH,
    parameter int P_REP_LIMIT  = c_DEF_REP_LIMIT
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [P_DATA_WIDTH-1:0]        adc_data,
    input  logic                           adc_or,
    output logic [P_WORD_WIDTH-1:0]        rnd_data,
    output logic                           rnd_valid,
    input  logic                           rnd_ready,
    output logic                           health_fail,
    output logic [c_DROP_CNT_W-1:0]        drop_count,
    output logic [$clog2(P_FIFO_DEPTH):0]  fifo_level
);

    localparam int                       c_REP_W    = $clog2(P_REP_LIMIT + 1);
    localparam logic [c_REP_W-1:0]       c_REP_ONE  = c_REP_W'(1);
    localparam logic [c_REP_W-1:0]       c_REP_MAX  = c_REP_W'(P_REP_LIMIT);
    localparam int                       c_BIT_W    = $clog2(P_WORD_WIDTH);
    localparam logic [c_BIT_W-1:0]       c_BIT_ONE  = c_BIT_W'(1);
    localparam logic [c_BIT_W-1:0]       c_BIT_LAST = c_BIT_W'(P_WORD_WIDTH - 1);
    localparam logic [c_DROP_CNT_W-1:0]  c_DROP_ONE = c_DROP_CNT_W'(1);

    // Input register
    logic [P_DATA_WIDTH-1:0] r_sample_q;
    logic                    r_smp_vld;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sample_q <= '0;
            r_smp_vld  <= 1'b0;
        end else begin
            r_sample_q <= adc_data;
            r_smp_vld  <= enable & ~adc_or;
        end
    end

    logic w_raw;
    assign w_raw = ^r_sample_q[P_TAP_BITS-1:0];

    // Repetition health test
    logic [P_DATA_WIDTH-1:0] r_prev;
    logic                    r_prev_vld;
    logic [c_REP_W-1:0]      r_rep_cnt;
    logic                    r_health_fail;
    logic                    w_same;
    logic [c_REP_W-1:0]      w_rep_next;
    logic                    w_rep_trip;
    logic                    w_bit_vld;

    assign w_same     = r_prev_vld && (r_sample_q == r_prev);
    assign w_rep_next = !w_same                ? c_REP_ONE :
                        (r_rep_cnt == c_REP_MAX) ? r_rep_cnt : r_rep_cnt + c_REP_ONE;
    assign w_rep_trip = (w_rep_next == c_REP_MAX);
    // The sample that trips the test must not contribute its bit.
    assign w_bit_vld  = r_smp_vld & ~r_health_fail & ~w_rep_trip;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev        <= '0;
            r_prev_vld    <= 1'b0;
            r_rep_cnt     <= '0;
            r_health_fail <= 1'b0;
        end else if (r_smp_vld) begin
            r_prev     <= r_sample_q;
            r_prev_vld <= 1'b1;
            r_rep_cnt  <= w_rep_next;
            if (w_rep_trip) begin
                r_health_fail <= 1'b1;
            end
        end
    end

    assign health_fail = r_health_fail;

    // Von Neumann debiaser
    logic [0:0] r_vn_state;
    logic [0:0] w_vn_next;
    logic       r_first;
    logic       w_first_next;
    logic       w_emit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vn_state <= c_VN_IDLE;
            r_first    <= 1'b0;
        end else begin
            r_vn_state <= w_vn_next;
            r_first    <= w_first_next;
        end
    end

    always_comb begin
        w_vn_next    = r_vn_state;
        w_first_next = r_first;
        w_emit       = 1'b0;
        if (!enable) begin
            w_vn_next    = c_VN_IDLE;
            w_first_next = 1'b0;
        end else if (w_bit_vld) begin
            case (r_vn_state)
                c_VN_IDLE: begin
                    w_first_next = w_raw;
                    w_vn_next    = c_VN_HAVE_FIRST;
                end
                c_VN_HAVE_FIRST: begin
                    w_emit    = (r_first != w_raw);
                    w_vn_next = c_VN_IDLE;
                end
                default: begin
                    w_vn_next = c_VN_IDLE;
                end
            endcase
        end
    end

    // Packer: LSB-first, the emitted bit is always the stored first bit
    logic [P_WORD_WIDTH-1:0] r_shift;
    logic [P_WORD_WIDTH-1:0] w_shift_next;
    logic [c_BIT_W-1:0]      r_bit_cnt;
    logic                    r_push_req;
    logic [P_WORD_WIDTH-1:0] r_push_word;

    assign w_shift_next = {r_first, r_shift[P_WORD_WIDTH-1:1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_push_req  <= 1'b0;
            r_push_word <= '0;
        end else begin
            r_push_req <= 1'b0;
            if (!enable) begin
                r_bit_cnt <= '0;
            end else if (w_emit) begin
                r_shift <= w_shift_next;
                if (r_bit_cnt == c_BIT_LAST) begin
                    r_push_req  <= 1'b1;
                    r_push_word <= w_shift_next;
                    r_bit_cnt   <= '0;
                end else begin
                    r_bit_cnt <= r_bit_cnt + c_BIT_ONE;
                end
            end
        end
    end

    // Output FIFO and overflow accounting
    logic w_fifo_full;
    logic w_fifo_empty;
    logic w_drop;
    logic [c_DROP_CNT_W-1:0] r_drop_cnt;

    rng_sync_fifo #(
        .WIDTH (P_WORD_WIDTH),
        .DEPTH (P_FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (r_push_req),
        .i_data  (r_push_word),
        .i_pop   (rnd_ready),
        .o_data  (rnd_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_level (fifo_level)
    );

    assign rnd_valid = ~w_fifo_empty;
    assign w_drop    = r_push_req & w_fifo_full & ~(rnd_valid & rnd_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + c_DROP_ONE;
        end
    end

    assign drop_count = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_adc_entropy_extractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_entropy_extractor
// Purpose  : Randomised scoreboard bench for adc_entropy_extractor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_entropy_extractor;

    localparam int DW    = 14;
    localparam int TAPS  = 4;
    localparam int WW    = 8;
    localparam int DEPTH = 16;
    localparam int LIMIT = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b1;
    logic [DW-1:0] adc_data = '0;
    logic          adc_or = 1'b1;
    logic [WW-1:0] rnd_data;
    logic          rnd_valid;
    logic          rnd_ready = 1'b1;
    logic          health_fail;
    logic [15:0]   drop_count;
    logic [4:0]    fifo_level;

    adc_entropy_extractor dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .adc_data    (adc_data),
        .adc_or      (adc_or),
        .rnd_data    (rnd_data),
        .rnd_valid   (rnd_valid),
        .rnd_ready   (rnd_ready),
        .health_fail (health_fail),
        .drop_count  (drop_count),
        .fifo_level  (fifo_level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model: bit stream -> words ----------------
    logic [WW-1:0] exp_q[$];
    int            exp_t[$];
    int            m_first;
    logic [WW-1:0] m_word;
    int            m_nbits;
    logic [DW-1:0] m_prev;
    bit            m_have_prev;
    int            m_rc;
    bit            m_hf;
    int            m_drop;
    int            m_gen;

    task automatic model_reset();
        exp_q.delete();
        exp_t.delete();
        m_first = -1; m_word = '0; m_nbits = 0;
        m_have_prev = 0; m_rc = 0; m_hf = 0; m_drop = 0; m_gen = 0;
    endtask

    task automatic model_emit(input logic b, input int t);
        m_word[m_nbits] = b;
        m_nbits++;
        if (m_nbits == WW) begin
            m_gen++;
            if (exp_q.size() >= DEPTH) m_drop++;
            else begin
                exp_q.push_back(m_word);
                exp_t.push_back(t);
            end
            m_nbits = 0;
        end
    endtask

    task automatic model_sample(input logic [DW-1:0] d, input logic orf, input int t);
        logic b;
        if (orf) return;
        if (m_have_prev && d == m_prev) m_rc++;
        else m_rc = 1;
        m_prev = d;
        m_have_prev = 1;
        if (m_hf) return;
        if (m_rc >= LIMIT) begin
            m_hf = 1;
            return;
        end
        b = ^d[TAPS-1:0];
        if (m_first < 0) m_first = int'(b);
        else begin
            if (m_first != int'(b)) model_emit(m_first[0], t);
            m_first = -1;
        end
    endtask

    // One sample per cycle; the word it completes should appear 3 edges on.
    task automatic step(input logic [DW-1:0] d, input logic orf);
        @(negedge clk);
        adc_data = d;
        adc_or   = orf;
        model_sample(d, orf, cyc + 3);
    endtask

    task automatic idle(input int n);
        repeat (n) step(DW'($urandom), 1'b1);
    endtask

    // ---------------- monitor ----------------
    logic [WW-1:0] last_pop = '0;
    logic          prev_valid = 1'b0;

    always @(negedge clk) begin
        #1;
        if (!reset) begin
            if (rnd_valid && !prev_valid && exp_t.size() > 0)
                check("latency_edge", cyc, exp_t[0]);
            if (rnd_valid && rnd_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 32'(rnd_data), 32'hDEAD);
                end else begin
                    check("word", 32'(rnd_data), 32'(exp_q[0]));
                    void'(exp_q.pop_front());
                    void'(exp_t.pop_front());
                end
                last_pop = rnd_data;
            end
        end
        prev_valid = rnd_valid;
    end

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            idle(1);
            k++;
        end
        check(name, 32'(exp_q.size()), 0);
        idle(3);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k;
        model_reset();
        #23;
        check("rst_valid", 32'(rnd_valid), 0);
        check("rst_data", 32'(rnd_data), 0);
        check("rst_health", 32'(health_fail), 0);
        check("rst_drop", 32'(drop_count), 0);
        check("rst_level", 32'(fifo_level), 0);
        reset = 1'b0;
        idle(2);

        // Pattern words
        repeat (8) begin step(14'h0000, 0); step(14'h0001, 0); end
        drain("pat00_drain");
        check("pat00", 32'(last_pop), 32'h00);
        repeat (8) begin step(14'h0001, 0); step(14'h0000, 0); end
        drain("patFF_drain");
        check("patFF", 32'(last_pop), 32'hFF);
        repeat (4) begin
            step(14'h0000, 0); step(14'h0001, 0);
            step(14'h0001, 0); step(14'h0000, 0);
        end
        drain("patAA_drain");
        check("patAA", 32'(last_pop), 32'hAA);

        // Only 00/11 pairs: nothing comes out
        repeat (50) begin
            step(14'h0000, 0); step(14'h0003, 0);
            step(14'h0001, 0); step(14'h0002, 0);
        end
        idle(4);
        check("discard_level", 32'(fifo_level), 0);
        check("discard_valid", 32'(rnd_valid), 0);
        check("discard_health", 32'(health_fail), 0);

        // Over-range gap inside a pair
        repeat (8) begin step(14'h0000, 0); step(14'h0005, 1); step(14'h0001, 0); end
        drain("gap0_drain");
        check("gap0", 32'(last_pop), 32'h00);
        repeat (8) begin step(14'h0001, 0); step(14'h0005, 1); step(14'h0000, 0); end
        drain("gap1_drain");
        check("gap1", 32'(last_pop), 32'hFF);

        // Random data with random over-range gaps
        repeat (400) step(DW'($urandom), ($urandom_range(0, 3) == 0));
        idle(2);
        drain("rand_drain");
        check("rand_level", 32'(fifo_level), 0);
        check("rand_drop", 32'(drop_count), 0);

        // Backpressure: 20 words into a 16-deep FIFO
        rnd_ready = 1'b0;
        k = m_gen;
        while (m_gen < k + 20 && m_gen < k + 100) step(DW'($urandom), 1'b0);
        idle(4);
        check("bp_level", 32'(fifo_level), 16);
        check("bp_drop", 32'(drop_count), 4);
        check("bp_drop_model", 32'(drop_count), 32'(m_drop));
        check("bp_queued", 32'(exp_q.size()), 16);
        rnd_ready = 1'b1;
        drain("bp_drain");
        check("bp_valid_after", 32'(rnd_valid), 0);
        check("bp_level_after", 32'(fifo_level), 0);

        // Async reset mid-word with 3 words buffered
        rnd_ready = 1'b0;
        k = 0;
        while (!(exp_q.size() == 3 && m_nbits == 5) && k < 5000) begin
            step(DW'($urandom), 1'b0);
            k++;
        end
        check("ar_setup", 32'(k < 5000), 1);
        idle(4);
        check("ar_level_pre", 32'(fifo_level), 3);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("ar_valid", 32'(rnd_valid), 0);
        check("ar_level", 32'(fifo_level), 0);
        check("ar_drop", 32'(drop_count), 0);
        model_reset();
        @(negedge clk);
        #2 reset = 1'b0;
        rnd_ready = 1'b1;
        k = 0;
        while (m_gen < 3 && k < 5000) begin
            step(DW'($urandom), 1'b0);
            k++;
        end
        idle(2);
        drain("ar_post_drain");

        // Repetition health test
        repeat (LIMIT - 1) step(14'h1234, 0);
        idle(3);
        check("hf_before", 32'(health_fail), 0);
        step(14'h1234, 0);
        idle(3);
        check("hf_after", 32'(health_fail), 1);
        check("hf_model", 32'(health_fail), 32'(m_hf));
        repeat (64) step(DW'($urandom), 1'b0);
        idle(4);
        check("hf_no_words", 32'(fifo_level), 0);
        check("hf_no_valid", 32'(rnd_valid), 0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("hf_cleared", 32'(health_fail), 0);
        model_reset();
        #4 reset = 1'b0;
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adc_entropy_extractor.md
# adc_entropy_extractor

Consumes the 14-bit ADC sample stream delivered by the ADC interface stage and turns it into debiased random bytes. Each accepted sample is reduced to one raw bit, continuously health-checked, von Neumann debiased, packed into bytes and buffered in a small FIFO. The FIFO feeds downstream consumers (host/UART/DMA) through a valid/ready handshake. The block runs in the ADC data-clock domain.

## Interface
- P_DATA_WIDTH, 14: ADC sample width.
- P_TAP_BITS, 4: number of sample LSBs folded by parity into one raw bit. Range 1..P_DATA_WIDTH.
- P_WORD_WIDTH, 8: output word width.
- P_FIFO_DEPTH, 16: FIFO depth in words. Must be a power of 2, at least 2.
- P_REP_LIMIT, 32: consecutive identical samples that trip the health test. At least 2.
- clk  in  1  ADC data clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- enable  in  1  accept samples when high.
- adc_data  in  P_DATA_WIDTH  ADC sample, valid every cycle.
- adc_or  in  1  over-range flag; the sample in that cycle is ignored.
- rnd_data  out  P_WORD_WIDTH  FIFO head word (show-ahead).
- rnd_valid  out  1  FIFO not empty.
- rnd_ready  in  1  consumer accepts the head word.
- health_fail  out  1  sticky repetition-test failure.
- drop_count  out  16  words dropped because the FIFO was full; saturates at 0xFFFF.
- fifo_level  out  $clog2(P_FIFO_DEPTH)+1  words currently held.

## Operation
- **Input register:** sample_q <= adc_data; smp_vld <= enable & !adc_or.
- **Raw bit:** raw = XOR of sample_q[P_TAP_BITS-1:0]. It is used only when smp_vld is 1.
- **Repetition test:** applies to valid samples only.
  - If sample_q equals the previous valid sample, rep_cnt increments; otherwise rep_cnt is set to 1.
  - When rep_cnt reaches P_REP_LIMIT, health_fail is set and stays set until reset.
  - While health_fail is 1, no raw bits enter the debiaser. The FIFO keeps draining.
  - Invalid samples update neither the previous-sample register nor rep_cnt.
- **Von Neumann FSM:** two states, IDLE and HAVE_FIRST.
  - IDLE: a valid raw bit is stored as `first`; go to HAVE_FIRST.
  - HAVE_FIRST: on a valid raw bit b, if first != b, emit `first` (pair 01 -> 0, pair 10 -> 1). Pairs 00 and 11 emit nothing. Go to IDLE.
  - Invalid samples leave the state unchanged, so a pair can span over-range gaps.
  - enable=0 forces IDLE and discards `first`.
- **Packer:** emitted bits are shifted in LSB-first (first bit goes to bit 0), counted by bit_cnt.
  - When bit P_WORD_WIDTH-1 arrives, the word is registered as a push request and bit_cnt returns to 0.
  - enable=0 clears bit_cnt, discarding any partial word.
- **FIFO push:**
  - Not full: the word is written.
  - Full with no pop this cycle: the word is dropped and drop_count increments (saturating).
  - Full with a pop in the same cycle: the push is accepted and the level is unchanged.
- **FIFO pop:** rnd_valid & rnd_ready advances the head.
- **Empty FIFO:** rnd_data holds its last value and is meaningless. rnd_valid=0.

## Timing
- Reset values:
  - rnd_valid=0, rnd_data=0, health_fail=0, drop_count=0, fifo_level=0.
  - FSM in IDLE, bit_cnt=0, rep_cnt=0.
  - The previous-sample register is marked empty, so the first valid sample after reset gives rep_cnt=1.
- Reset asserted mid-operation clears everything immediately, including FIFO pointers, any partial word and any buffered words. Outputs go to their reset values without waiting for a clock edge.
- Latency: the sample completing a word is captured at edge k. The packed word is registered at edge k+1 and written to the FIFO at edge k+2. rnd_valid is high after edge k+2.
- Throughput:
  - At most one debiased bit per two valid samples.
  - At most one push and one pop per cycle.
  - A FIFO pop (rnd_valid & rnd_ready) is observed at the edge; the next head word is presented after that edge.
- fifo_level and rnd_valid update on the same edge as the push or pop.
- health_fail asserts after the edge at which the P_REP_LIMIT-th identical valid sample is processed. That sample's raw bit is not used.

## Structure
- The shared package rng_pkg holds:
  - default widths, depth and limit constants;
  - the von Neumann state encoding (IDLE=1'b0, HAVE_FIRST=1'b1);
  - the drop_count width constant (16).
- One sub-module: rng_sync_fifo.
  - Parameterised width and depth, show-ahead read, full/empty/level outputs.
  - Asynchronous active-high reset on its pointers.
- The input register, health test, FSM, packer and drop counter stay in adc_entropy_extractor.

## Test plan
- **Pattern words** (enable=1, adc_or=0, rnd_ready=1):
  - alternating adc_data 0x0000,0x0001 (8 pairs "01") -> rnd_data=0x00;
  - 0x0001,0x0000 x8 -> 0xFF;
  - pairs alternating 01/10 -> 0xAA;
  - each rnd_valid is high 2 edges after the completing sample is captured.
- **Discarded pairs:** 200 samples alternating 0x0000,0x0003 and 0x0001,0x0002 (pairs 00 and 11 only) -> rnd_valid stays 0, health_fail stays 0.
- **Over-range gap:** pair "0 x 1" with adc_or=1 on the middle sample (0x0005) -> the pair completes as 01 and a 0 bit is emitted. Word contents match the same sequence without the gap.
- **Health test:** 0x1234 held for 32 valid cycles -> health_fail=1 after the 32nd. A further 64 samples of varied data produce no new words. Reset pulse -> health_fail=0.
- **Backpressure:** rnd_ready=0 while generating 20 words -> fifo_level=16, drop_count=4. Then rnd_ready=1 -> 16 words out in generation order, then rnd_valid=0 and fifo_level=0.
- **Async reset:** reset asserted mid-word (bit_cnt=5, FIFO level 3), between clock edges -> rnd_valid, fifo_level and drop_count read 0 immediately. After release, the first output word is built only from post-reset bits.
